// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer: data stage over instruction fetch, fixed latency.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic        dm_word,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_word,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_data
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || MAX_DATA_STREAK < 1) begin : g_bad_param
        $error("mem_port_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD =
        (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        req_any;
    logic        grant;
    logic        pick_data;
    logic        resp;
    logic [7:0]  lane;

    assign req_any = if_req | dm_req;
    assign grant   = (state == IDLE) && req_any;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;
    logic          force_fetch;

    assign force_fetch = if_req && (streak >= STREAK_MAX);
    assign pick_data   = dm_req && !force_fetch;

    // Counts only data grants that made a waiting fetch wait longer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant) begin
            if (!pick_data || !if_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end
`else
    assign pick_data = dm_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_any) state_nxt = ACCESS;
            ACCESS:  state_nxt = (MEM_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_word   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_data <= 1'b0;
        end else begin
            mem_en <= grant;
            if (grant) begin
                grant_data <= pick_data;
                mem_we     <= pick_data & dm_write;
                mem_word   <= pick_data ? dm_word : 1'b1;
                mem_addr   <= pick_data ? dm_addr : if_addr;
                mem_wdata  <= pick_data ? dm_wdata : 32'd0;
            end
            if (state == ACCESS) begin
                cnt <= WAIT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign resp = (state == RESP);

    always_comb begin
        lane = mem_rdata[7:0];
        unique case (mem_addr[1:0])
            2'd0: lane = mem_rdata[7:0];
            2'd1: lane = mem_rdata[15:8];
            2'd2: lane = mem_rdata[23:16];
            2'd3: lane = mem_rdata[31:24];
            default: lane = mem_rdata[7:0];
        endcase
    end

    assign if_ack   = resp && !grant_data;
    assign dm_ack   = resp && grant_data;
    assign if_rdata = if_ack ? mem_rdata : 32'd0;

    always_comb begin
        dm_rdata = 32'd0;
        if (dm_ack && !mem_we) begin
            dm_rdata = mem_word ? mem_rdata : {{24{lane[7]}}, lane};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency 2 main instance, latency 1 side instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_write;
    logic        dm_word;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;

    logic        if_ack, dm_ack, mem_en, mem_we, mem_word, busy, grant_data;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        u1_if_ack, u1_dm_ack, u1_mem_en, u1_mem_we, u1_mem_word;
    logic        u1_busy, u1_grant_data;
    logic [31:0] u1_if_rdata, u1_dm_rdata, u1_mem_addr, u1_mem_wdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_write(dm_write), .dm_word(dm_word),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_word(mem_word),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_data(grant_data)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(u1_if_ack), .if_rdata(u1_if_rdata),
        .dm_req(dm_req), .dm_write(dm_write), .dm_word(dm_word),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(u1_dm_ack), .dm_rdata(u1_dm_rdata),
        .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_word(u1_mem_word),
        .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rdata(mem_rdata),
        .busy(u1_busy), .grant_data(u1_grant_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_dm(input string tag, input logic wr, input logic wd,
                         input logic [31:0] a, input logic [31:0] wdat,
                         input logic [31:0] rd, input logic [31:0] exp_r);
        dm_req = 1'b1; dm_write = wr; dm_word = wd;
        dm_addr = a; dm_wdata = wdat; mem_rdata = rd;
        step();
        chk({tag, "_en"}, mem_en, 1);
        chk({tag, "_gd"}, grant_data, 1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_word"}, mem_word, wd);
        step();
        step();
        chk({tag, "_ack"}, dm_ack, 1);
        chk({tag, "_rdata"}, dm_rdata, exp_r);
        dm_req = 1'b0;
        step();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_rd0"}, dm_rdata, 0);
    endtask

    function automatic logic exp_grant(input int i);
`ifdef ARB_STARVE_GUARD_EN
        return (i % 5) != 4;
`else
        return (i < 0) ? 1'b0 : 1'b1;
`endif
    endfunction

    initial begin
        int g;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_write = 1'b0; dm_word = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_grant_data", grant_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {if_ack, dm_ack}, 0);
        rst_n = 1'b1;
        step();

        // single fetch
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h8C220004;
        step();
        chk("f_en", mem_en, 1);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_we_word", {mem_we, mem_word}, 32'h1);
        chk("f_busy", busy, 1);
        step();
        chk("f_wait_en", mem_en, 0);
        chk("f_wait_ack", if_ack, 0);
        step();
        chk("f_ack", if_ack, 1);
        chk("f_rdata", if_rdata, 32'h8C220004);
        chk("f_dm_ack", dm_ack, 0);
        if_req = 1'b0;
        step();
        chk("f_idle", busy, 0);
        chk("f_rd0", if_rdata, 0);

        // loads
        do_dm("lb3", 1'b0, 1'b0, 32'h203, 32'h0, 32'h80FF1234, 32'hFFFFFF80);
        do_dm("lb1", 1'b0, 1'b0, 32'h201, 32'h0, 32'h80FF1234, 32'h00000012);
        do_dm("lb0", 1'b0, 1'b0, 32'h204, 32'h0, 32'h5566_7788, 32'hFFFFFF88);
        do_dm("lw", 1'b0, 1'b1, 32'h208, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        do_dm("lwu", 1'b0, 1'b1, 32'h20A, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF);
        do_dm("sb", 1'b1, 1'b0, 32'h20C, 32'h0000_00A5, 32'h1111_1111, 32'h0);

        // simultaneous: store word wins, then fetch
        dm_req = 1'b1; dm_write = 1'b1; dm_word = 1'b1;
        dm_addr = 32'h300; dm_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h0000_0013;
        step();
        chk("s_gd", grant_data, 1);
        chk("s_we", mem_we, 1);
        chk("s_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_addr", mem_addr, 32'h300);
        step();
        step();
        chk("s_dm_ack", dm_ack, 1);
        chk("s_dm_rd", dm_rdata, 0);
        chk("s_if_ack0", if_ack, 0);
        dm_req = 1'b0;
        step();
        chk("s_idle", busy, 0);
        step();
        chk("s_f_en", mem_en, 1);
        chk("s_f_gd", grant_data, 0);
        chk("s_f_addr", mem_addr, 32'h500);
        chk("s_f_we", mem_we, 0);
        step();
        step();
        chk("s_f_ack", if_ack, 1);
        chk("s_f_rd", if_rdata, 32'h0000_0013);
        if_req = 1'b0;
        step();

        // both requests held high continuously
        dm_req = 1'b1; dm_write = 1'b0; dm_word = 1'b1; dm_addr = 32'h400;
        if_req = 1'b1; if_addr = 32'h600;
        step();
        g = 0;
        for (int c = 0; c < 100 && g < 10; c++) begin
            if (mem_en) begin
                chk($sformatf("streak_g%0d", g), grant_data, exp_grant(g));
                g++;
            end
            step();
        end
        chk("streak_count", g, 10);
        dm_req = 1'b0; if_req = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("streak_idle", busy, 0);

        // reset mid-WAIT of a data load
        dm_req = 1'b1; dm_write = 1'b0; dm_word = 1'b1; dm_addr = 32'h208;
        mem_rdata = 32'h7777_0001;
        step();
        step();
        chk("r_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_outs", {mem_en, mem_we, mem_word, grant_data, dm_ack, if_ack}, 0);
        chk("r_addr", mem_addr, 0);
        chk("r_wdata", mem_wdata, 0);
        step();
        chk("r_no_ack", dm_ack, 0);
        chk("r_no_rd", dm_rdata, 0);
        dm_req = 1'b0;
        step();
        rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h0040_0093;
        step();
        chk("r2_en", mem_en, 1);
        chk("r2_addr", mem_addr, 32'h40);
        step();
        chk("r2_ack0", if_ack, 0);
        step();
        chk("r2_ack", if_ack, 1);
        chk("r2_rd", if_rdata, 32'h0040_0093);
        if_req = 1'b0;
        for (int c = 0; c < 6; c++) step();

        // latency 1 instance
        chk("l1_idle", u1_busy, 0);
        if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h0000_0013;
        step();
        chk("l1_en", u1_mem_en, 1);
        chk("l1_addr", u1_mem_addr, 32'h80);
        step();
        chk("l1_ack", u1_if_ack, 1);
        chk("l1_rd", u1_if_rdata, 32'h0000_0013);
        step();
        chk("l1_idle2", u1_busy, 0);
        chk("l1_ack0", u1_if_ack, 0);
        step();
        chk("l1_next_en", u1_mem_en, 1);
        if_req = 1'b0;
        for (int c = 0; c < 6; c++) step();
        chk("end_idle", {busy, u1_busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between instruction fetch (IF) and the data-memory stage (LDB/LDW/STB/STW, driven by the decode control bits memRead/memWrite/word). The arbiter is a multi-cycle sequencer. It grants one requester, drives the memory for one access, waits a fixed latency, and returns an acknowledge. Byte loads are sign-extended to 32 bits here, so the register file always receives full words.

## Interface
- MEM_LATENCY, 2: cycles from the mem_en cycle to the cycle in which mem_rdata is valid; legal range 1..15.
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch waits; used only with ARB_STARVE_GUARD_EN.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  32  fetched instruction word.
- dm_req  in  1  data request (memRead|memWrite); held until dm_ack.
- dm_write  in  1  1 = store, 0 = load.
- dm_word  in  1  1 = word access, 0 = byte access.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data; byte stores use bits [7:0].
- dm_ack  out  1  one-cycle pulse; dm_rdata valid this cycle (loads).
- dm_rdata  out  32  load result.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  write enable, valid with mem_en.
- mem_word  out  1  word/byte size, valid with mem_en.
- mem_addr  out  32  latched access address.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  aligned memory word.
- busy  out  1  state != IDLE.
- grant_data  out  1  1 = current/last grant went to the data port.

## Operation
- FSM states:
  - IDLE: samples requests.
  - ACCESS: exactly one cycle; mem_en=1.
  - WAIT: MEM_LATENCY-1 cycles, down-counter; skipped when MEM_LATENCY=1.
  - RESP: one cycle; ack for the granted port.
- IDLE -> ACCESS when either request is high. Address, size, write and wdata are latched on this edge.
- ACCESS -> WAIT, or directly to RESP when MEM_LATENCY=1.
- WAIT -> RESP when the counter reaches 0.
- RESP -> IDLE unconditionally. There is no IDLE bypass, so back-to-back accesses are spaced MEM_LATENCY+2 cycles apart.
- Priority: dm_req beats if_req, because the data request belongs to the older instruction. Simultaneous requests grant data.
- Fetch accesses are always word reads: mem_we=0, mem_word=1.
- Byte load: dm_rdata = sign-extend of byte addr[1:0] of mem_rdata (little-endian: 0 -> [7:0], 3 -> [31:24]).
- Word load: dm_rdata = mem_rdata. Word addresses with addr[1:0]!=0 are passed through unaligned.
- Stores wait the full latency and ack in RESP. dm_rdata=0 for stores.
- if_rdata and dm_rdata are 0 outside their ack cycle.
- A requester that drops its req before ack is a protocol violation. The latched transaction still completes and acks.
- Reset, including mid-transaction: FSM -> IDLE, counter and streak count -> 0. All outputs are 0, grant_data included. The in-flight access is abandoned with no ack.

## Timing
- Request high in IDLE cycle R: mem_en in R+1, mem_rdata consumed in R+1+MEM_LATENCY, ack in R+1+MEM_LATENCY.
- Ack and rdata are combinational from state and mem_rdata during RESP. All other outputs are registered.
- With MEM_LATENCY=2: ack at R+3, next grant sampled at R+4.
- Requests arriving while busy are held by the requester and evaluated in the next IDLE cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined: a saturating streak counter counts consecutive data grants made while if_req was high.
  - When the count reaches MAX_DATA_STREAK and if_req is high, the next grant goes to fetch, even if dm_req is high.
  - Any fetch grant clears the counter.
- ARB_STARVE_GUARD_EN undefined: strict data priority. No streak counter logic is present, and MAX_DATA_STREAK is ignored.

## Test plan
- Reset mid-WAIT of a data load: rst_n low in R+2 -> busy=0, all outputs 0, no dm_ack. After release, a new if_req (addr 0x40) acks at R'+3.
- Single fetch, MEM_LATENCY=2, if_addr=0x100, mem_rdata=0x8C220004: mem_en/addr at R+1, if_ack with if_rdata=0x8C220004 at R+3, busy falls at R+4.
- Byte load dm_addr=0x203, mem_rdata=0x80FF1234: dm_rdata=0xFFFFFF80. Addr 0x201 gives 0x00000012.
- Simultaneous if_req and dm_req (store word 0xDEADBEEF to 0x300): data granted first (mem_we=1, mem_wdata=0xDEADBEEF), dm_ack at R+3. Fetch is granted at R+4 and acks at R+7.
- With ARB_STARVE_GUARD_EN, MAX_DATA_STREAK=4, dm_req and if_req held high continuously: grant sequence D,D,D,D,F,D,D,D,D,F. Without the macro: fetch is never granted while dm_req stays high.
- MEM_LATENCY=1: ACCESS -> RESP, no WAIT. Ack at R+2, 3-cycle throughput.
